// File: rtl/word_narrower.sv
// ---------------------------------------------------------------------------
// word_narrower
//
// Narrows 32-bit ALU words to 16-bit halfwords for the halfword store path.
// Each accepted word is checked for representability in signed or unsigned
// 16-bit form. Words that do not fit are flagged with out_ovf. When they do
// not fit they are either saturated or truncated, depending on the build.
// Results pass through a 2-entry output FIFO with valid/ready handshakes on
// both sides. A sticky, saturating counter tracks how many accepted words
// overflowed.
//
// Build option:
//   WORD_NARROWER_SAT_EN  defined   -> overflowing words saturate
//                                      (signed: 7FFF/8000, unsigned: FFFF)
//                         undefined -> overflowing words truncate to [15:0]
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_data/in_signed valid
//   in_ready   out  1   unit can accept a word (registered state only)
//   in_data    in   32  word to narrow
//   in_signed  in   1   1 = signed range check, 0 = unsigned range check
//   out_valid  out  1   out_data/out_ovf valid (FIFO not empty)
//   out_ready  in   1   consumer takes the head entry
//   out_data   out  16  narrowed halfword (FIFO head)
//   out_ovf    out  1   head word was not representable
//   ovf_cnt    out  16  saturating count of accepted overflowing words
//   cnt_clr    in   1   synchronous clear of ovf_cnt (wins over increment)
// ---------------------------------------------------------------------------
module word_narrower (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic [15:0] ovf_cnt,
  input  logic        cnt_clr
);

  // -------------------------------------------------------------------------
  // Representability check and narrowing
  // -------------------------------------------------------------------------
  logic        fits_signed;
  logic        fits_unsigned;
  logic        ovf;
  logic [15:0] narrowed;

  // A signed value fits in 16 bits when bits [31:15] are all copies of the
  // sign bit. An unsigned value fits when the upper half is all zeros.
  assign fits_signed   = (in_data[31:15] == 17'h00000) ||
                         (in_data[31:15] == 17'h1FFFF);
  assign fits_unsigned = (in_data[31:16] == 16'h0000);
  assign ovf           = in_signed ? ~fits_signed : ~fits_unsigned;

`ifdef WORD_NARROWER_SAT_EN
  always_comb begin
    narrowed = in_data[15:0];
    if (ovf) begin
      if (in_signed) begin
        narrowed = in_data[31] ? 16'h8000 : 16'h7FFF;
      end else begin
        narrowed = 16'hFFFF;
      end
    end
  end
`else
  // Truncation: the low half passes through whether or not the word fits.
  assign narrowed = in_data[15:0];
`endif

  // -------------------------------------------------------------------------
  // 2-entry output FIFO of {data, ovf}
  // -------------------------------------------------------------------------
  logic [16:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // in_ready looks only at count. When the FIFO is full, a pop in the same
  // cycle does not open a slot for a push. This keeps in_ready free of any
  // combinational path from out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = fifo_mem[rd_ptr][16:1];
  assign out_ovf   = fifo_mem[rd_ptr][0];

  // Storage is cleared on reset so that out_data/out_ovf read as zero
  // while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= 17'h00000;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= {narrowed, ovf};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;   // idle, or push and pop together
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Overflow event counter: saturates at FFFF, and clear beats increment
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 16'h0000;
    end else if (cnt_clr) begin
      ovf_cnt <= 16'h0000;
    end else if (push && ovf && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_word_narrower.sv
// ---------------------------------------------------------------------------
// tb_word_narrower
//
// Self-checking bench for word_narrower. A table of {input, expected} records
// runs first. Hand-written sequences follow for backpressure, counter
// saturation/clear and asynchronous reset. Expected results are queued when
// a word is accepted. A monitor compares the FIFO head, the flags and the
// counter on every falling edge.
// ---------------------------------------------------------------------------
module tb_word_narrower;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [15:0] ovf_cnt;
  logic        cnt_clr;

  word_narrower dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entry: {data, ovf}
  logic [16:0] sb_q[$];
  logic [16:0] pend_exp;     // expected result of the word currently offered
  logic [15:0] exp_cnt;
  bit          quiet;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the narrowing, built from integer range tests.
  function automatic logic [16:0] model(input logic [31:0] d, input logic s);
    longint      v;
    bit          o;
    logic [15:0] r;
    if (s) begin
      v = longint'($signed(d));
      o = (v > 32767) || (v < -32768);
    end else begin
      v = longint'(d);
      o = (v > 65535);
    end
    r = d[15:0];
`ifdef WORD_NARROWER_SAT_EN
    if (o) r = s ? ((v < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
    return {r, o};
  endfunction

  // Monitor: compare on every falling edge, then apply the transfers that
  // the next rising edge will perform to the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(sb_q.size() != 2));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
    if (sb_q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(sb_q[0][16:1]));
      chk("out_ovf", 32'(out_ovf), 32'(sb_q[0][0]));
    end
    if (rst_n) begin
      if (out_valid && out_ready && sb_q.size() != 0) begin
        if (!quiet) $display("pop  data=%h ovf=%b cnt=%h", out_data, out_ovf, ovf_cnt);
        void'(sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(pend_exp);
        if (cnt_clr) exp_cnt = 16'h0000;
        else if (pend_exp[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
      end else if (cnt_clr) begin
        exp_cnt = 16'h0000;
      end
    end
  end

  // Offer one word until it is accepted (bounded), with an explicit expectation.
  task automatic send(input logic [31:0] d, input logic s, input logic [16:0] e);
    bit ok;
    ok        = 1'b0;
    in_data   = d;
    in_signed = s;
    pend_exp  = e;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %h not accepted, in_ready=%b required 1", d, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!quiet) $display("push data=%h signed=%b exp=%h ovf=%b", d, s, e[16:1], e[0]);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic        sgn;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  localparam bit SAT = `ifdef WORD_NARROWER_SAT_EN 1'b1 `else 1'b0 `endif;

  vec_t tbl [12];
  int   tbl_ovf;

  initial begin
    tbl[0]  = '{32'hFFFF_8000, 1'b1, 16'h8000, 1'b0};
    tbl[1]  = '{32'h0001_2345, 1'b1, SAT ? 16'h7FFF : 16'h2345, 1'b1};
    tbl[2]  = '{32'h0000_FFFF, 1'b0, 16'hFFFF, 1'b0};
    tbl[3]  = '{32'h0001_0000, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1};
    tbl[4]  = '{32'h0000_7FFF, 1'b1, 16'h7FFF, 1'b0};
    tbl[5]  = '{32'h0000_8000, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b1};
    tbl[6]  = '{32'hFFFF_7FFF, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1};
    tbl[7]  = '{32'hFFFF_FFFF, 1'b0, 16'hFFFF, 1'b1};
    tbl[8]  = '{32'h8000_0000, 1'b1, SAT ? 16'h8000 : 16'h0000, 1'b1};
    tbl[9]  = '{32'h0000_0000, 1'b0, 16'h0000, 1'b0};
    tbl[10] = '{32'hFFFF_FFFF, 1'b1, 16'hFFFF, 1'b0};
    tbl[11] = '{32'h0000_8000, 1'b0, 16'h8000, 1'b0};

    quiet     = 1'b0;
    exp_cnt   = 16'h0000;
    pend_exp  = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset values
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, consumer always ready
    out_ready = 1'b1;
    tbl_ovf   = 0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].data, tbl[i].sgn, {tbl[i].exp_data, tbl[i].exp_ovf});
      if (tbl[i].exp_ovf) tbl_ovf++;
    end
    drain();
    chk("tbl_ovf_cnt", 32'(ovf_cnt), 32'(tbl_ovf));

    // Backpressure: A, B accepted, C held until the consumer resumes
    out_ready = 1'b0;
    send(32'h0000_00A1, 1'b0, {16'h00A1, 1'b0});
    send(32'h0000_00B2, 1'b1, {16'h00B2, 1'b0});
    fork
      send(32'h0003_00C3, 1'b1, {SAT ? 16'h7FFF : 16'h00C3, 1'b1});
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Counter clear with no traffic
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("clr_idle", 32'(ovf_cnt), 32'h0);

    // Counter saturation: 65535 overflowing words at full rate, then one more
    quiet = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      logic [31:0] d;
      d = {(16'(i) & 16'h7FFF) | 16'h0001, 16'(i * 7)};
      send(d, i[0], model(d, i[0]));
    end
    quiet = 1'b0;
    $display("bulk 65535 overflowing words sent, cnt=%h", ovf_cnt);
    chk("cnt_at_max", 32'(ovf_cnt), 32'hFFFF);
    send(32'h0001_0000, 1'b0, model(32'h0001_0000, 1'b0));
    drain();
    chk("cnt_held_max", 32'(ovf_cnt), 32'hFFFF);

    // Clear in the same cycle as an overflowing word: clear wins
    cnt_clr = 1'b1;
    send(32'h0000_8000, 1'b1, {SAT ? 16'h7FFF : 16'h8000, 1'b1});
    cnt_clr = 1'b0;
    drain();
    chk("clr_wins", 32'(ovf_cnt), 32'h0);

    // Build up a nonzero count and two buffered entries, then reset mid-cycle
    send(32'h0002_0000, 1'b0, {SAT ? 16'hFFFF : 16'h0000, 1'b1});
    drain();
    out_ready = 1'b0;
    send(32'h0000_1111, 1'b0, {16'h1111, 1'b0});
    send(32'h0000_2222, 1'b0, {16'h2222, 1'b0});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    exp_cnt = 16'h0000;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    chk("arst_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_word", 32'(out_valid), 32'd0);
    send(32'hFFFF_FFFE, 1'b1, {16'hFFFE, 1'b0});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
